uart_rx_byte: RTL
=================

# uart_rx_byte

Byte-level UART receiver for the GPS signal generator's configuration path. It samples the asynchronous serial line on the configuration input pin and deserializes 8N1 frames (idle high, LSB first) into bytes. Each byte is delivered with a one-cycle valid strobe to the register bank's frame decoder, which is directly downstream. Malformed frames are flagged and never delivered as data.

## Interface
- `CLKS_PER_BIT`, default 142: clock cycles per UART bit. Legal range is >= 4. `HALF = (CLKS_PER_BIT-1)/2` uses integer division, so HALF = 70 at the default.
- `clk_in`  input  1  the single system clock; all logic is on its rising edge.
- `rst_in`  input  1  reset, synchronous and active-high.
- `rx_in`  input  1  asynchronous serial line, idle high.
- `data_out`  output  8  last correctly framed byte; held until the next good frame.
- `valid_out`  output  1  one-cycle pulse when `data_out` has just been updated.
- `frame_err_out`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy_out`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** a 2-flop synchronizer feeds `rx_s`. Both flops reset to 1. The FSM only ever looks at `rx_s`.
- **Counters:** bit counter `cnt` is $clog2(CLKS_PER_BIT) bits wide. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **IDLE:** on `rx_s==0`, go to START with `cnt=0`.
- **START:** while `cnt!=HALF`, increment `cnt`. When `cnt==HALF`:
  - if `rx_s==0`, go to DATA with `cnt=0`, `idx=0`;
  - otherwise go to IDLE. This is a glitch: no flag is raised.
- **DATA:** while `cnt!=CLKS_PER_BIT-1`, increment `cnt`. When `cnt==CLKS_PER_BIT-1`:
  - `sh[idx] <= rx_s` (LSB first), `cnt=0`;
  - if `idx==7`, go to STOP; otherwise increment `idx`.
- **STOP:** the same count runs to `CLKS_PER_BIT-1`, then:
  - if `rx_s==1`: `data_out<=sh`, `valid_out=1` for that one cycle, go to IDLE;
  - if `rx_s==0`: `frame_err_out=1` for one cycle, `data_out` is unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. This keeps a break condition from re-triggering start detection.
- **Output rules:**
  - `valid_out` and `frame_err_out` are registered, mutually exclusive, and never high for two consecutive cycles.
  - `busy_out = (state!=IDLE)`, registered with the state.

## Timing
- **Reset values:** `data_out=8'h00`, `valid_out=0`, `frame_err_out=0`, `busy_out=0`, state IDLE, synchronizer flops 1, `cnt`/`idx`/`sh` = 0.
- **Reference edge E0:** the first rising edge of `clk_in` that samples `rx_in` low.
  - START is entered at E0+2.
  - The start bit is sampled at edge E0+HALF+3 (E0+73 at the default).
- **Sample points:** with S = E0+HALF+3:
  - data bit i is sampled at edge S+(i+1)·CLKS_PER_BIT;
  - the stop bit is sampled at S+9·CLKS_PER_BIT.
- **Output latency:** `valid_out` or `frame_err_out` is high for exactly the cycle following edge S+9·CLKS_PER_BIT. At the default this is edge E0+1351.
- **busy_out window:**
  - good frame or glitch: high from E0+2 until the edge on which IDLE is re-entered;
  - frame error: stays high through WAIT_IDLE.
- **Back-to-back frames:** a new start edge arriving at any time after the stop sample is accepted. A full 8N1 frame at exactly CLKS_PER_BIT per bit loses no bytes.
- **Baud tolerance:** correct reception is required for bit periods in CLKS_PER_BIT ±2%.
- **Reset mid-operation:** the FSM returns to IDLE on the next edge with no `valid_out` or `frame_err_out` pulse. `data_out` returns to 0. If `rx_in` is low when reset is released, a start is detected 2 cycles after release, because the synchronizer flops come out of reset at 1.
- **Simultaneous events:** in IDLE, a low `rx_s` in the same cycle as `rst_in` is ignored; reset wins.

## Test plan
1. **Single byte:** reset, then send 0xA5 at 142 clocks/bit → `valid_out` pulses once at E0+1351, `data_out=0xA5`, `frame_err_out` stays 0, `busy_out` falls on that edge.
2. **Glitch:** drive `rx_in` low for 20 clocks, then high → no `valid_out` or `frame_err_out`; `busy_out` is high from E0+2 to E0+73; `data_out` is unchanged.
3. **Framing error:** send 0x3C with the stop bit low and hold the line low for 500 more clocks → `frame_err_out` pulses once at E0+1351, `data_out` keeps its previous value, `busy_out` stays high until the line returns high. A following 0x3C sent with a correct stop bit → `valid_out`, `data_out=0x3C`.
4. **Back-to-back:** send 0x00, 0xFF, 0x81 with exactly one stop bit each → three `valid_out` pulses 1420 clocks apart, with data 0x00, 0xFF, 0x81 in order.
5. **Reset mid-frame:** assert `rst_in` for one cycle during data bit 4 → no pulse and `data_out=0x00`. The next frame, 0x5A, is received correctly.
6. **Baud tolerance:** send 0x55 at 139 and at 145 clocks/bit → `data_out=0x55` with `valid_out` in both cases, and no `frame_err_out`.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Byte-level 8N1 UART receiver (idle high, LSB first) for the configuration
// path. Good frames update data_out with a one-cycle valid_out strobe; frames
// whose stop bit samples low raise a one-cycle frame_err_out strobe and are
// never delivered as data.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        synchronous active-high reset
//   rx_in         asynchronous serial line, idle high
//   data_out      last correctly framed byte, held until the next good frame
//   valid_out     one-cycle pulse when data_out has just been updated
//   frame_err_out one-cycle pulse when the stop bit is sampled low
//   busy_out      high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a low synchronized rx
// START     | counting to mid start bit, then confirming it is still low
// DATA      | sampling 8 data bits, one per CLKS_PER_BIT, LSB first
// STOP      | sampling the stop bit, delivering the byte or flagging error
// WAIT_IDLE | after a framing error, holding off until the line is high
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_sh;
    logic            w_rx_s;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // Synchronizer resets to the idle level so a line already low at
            // release is seen as a fresh start two cycles later.
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_sh          <= '0;
            data_out      <= 8'h00;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            r_sync1       <= rx_in;
            r_sync2       <= r_sync1;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= START;
                        r_cnt    <= '0;
                        busy_out <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt != HALF) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_rx_s) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        // Line went high again before mid start bit: glitch.
                        r_state  <= IDLE;
                        busy_out <= 1'b0;
                    end
                end

                DATA: begin
                    if (r_cnt != LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_sh[r_idx] <= w_rx_s;
                        r_cnt       <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (r_cnt != LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            data_out  <= r_sh;
                            valid_out <= 1'b1;
                            r_state   <= IDLE;
                            busy_out  <= 1'b0;
                        end else begin
                            frame_err_out <= 1'b1;
                            r_state       <= WAIT_IDLE;
                        end
                    end
                end

                WAIT_IDLE: begin
                    // A held-low break must not look like a new start bit.
                    if (w_rx_s) begin
                        r_state  <= IDLE;
                        busy_out <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
